alu_result_mux_buf: RTL and testbench

- Parametrised successor to the combinational ALU result selector.
- Selects one of NUM_IN operation results (each WIDTH bits) using the ALUControl code.
- Registers the selected result with derived flags.
- Presents the result through a 2-entry valid/ready buffer, so the ALU datapath can stall against a downstream consumer (register-file writeback or flag unit) without losing results.

---
 rtl/alu_mux_pkg.sv | 23 ++
 rtl/mux_sel_n.sv | 18 +
 rtl/alu_result_mux_buf.sv | 74 +++++++
 tb/tb_alu_result_mux_buf.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_mux_pkg.sv
// alu_mux_pkg: shared ALU result-select codes, defaults and buffer types
package alu_mux_pkg;
  localparam int DEF_WIDTH = 5;
  localparam int DEF_NUM_IN = 10;
  localparam int DEF_SEL_W = 4;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_NOR = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;
  typedef struct packed {
    logic [DEF_WIDTH-1:0] q;
    logic zero;
    logic neg;
    logic sel_err;
  } alu_entry_t;
endpackage

// File: rtl/mux_sel_n.sv
// mux_sel_n: N:1 result selector, zero output and err flag for out-of-range codes
module mux_sel_n #(
  parameter int WIDTH = 5,
  parameter int NUM_IN = 10,
  parameter int SEL_W = 4
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        q,
  output logic                    err
);
  assign err = int'(sel) >= NUM_IN;
  always_comb begin
    q = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (int'(sel) == i) q = in_data[i*WIDTH +: WIDTH];
  end
endmodule

// File: rtl/alu_result_mux_buf.sv
// alu_result_mux_buf: ALU result select plus flags, held in a 2-entry valid/ready buffer
module alu_result_mux_buf
  import alu_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        alu_control,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_q,
  output logic                    out_zero,
  output logic                    out_neg,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready
);
  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic zero;
    logic neg;
    logic sel_err;
  } entry_t;
  entry_t head, tail, new_e;
  occ_t occ;
  logic rst_state, push, pop, sel_err;
  logic [WIDTH-1:0] sel_q;
  mux_sel_n #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_mux (
    .in_data(in_data),
    .sel(alu_control),
    .q(sel_q),
    .err(sel_err)
  );
  assign new_e = '{q: sel_q, zero: !sel_err && sel_q == '0, neg: sel_q[WIDTH-1], sel_err: sel_err};
  assign in_ready = !rst_state && occ != FULL;
  assign out_valid = occ != EMPTY;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign out_q = head.q;
  assign out_zero = head.zero;
  assign out_neg = head.neg;
  assign out_sel_err = head.sel_err;
  // in ONE with push&pop the new entry overwrites the head directly; tail only fills going to FULL
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= EMPTY;
      head <= '0;
      tail <= '0;
      rst_state <= 1'b1;
    end else begin
      rst_state <= 1'b0;
      case (occ)
        EMPTY: if (push) begin
          head <= new_e;
          occ <= ONE;
        end
        ONE: if (push && pop) head <= new_e;
          else if (push) begin
            tail <= new_e;
            occ <= FULL;
          end else if (pop) occ <= EMPTY;
        FULL: if (pop) begin
          head <= tail;
          occ <= ONE;
        end
        default: occ <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_result_mux_buf.sv
// tb_alu_result_mux_buf: directed test-plan scenarios plus a randomized queue-model run
module tb_alu_result_mux_buf;
  localparam int W = 5;
  localparam int N = 10;
  localparam int NW = N * W;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NW-1:0] in_data;
  logic [3:0] alu_control = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] out_q;
  logic out_zero, out_neg, out_sel_err, out_valid;
  logic out_ready = 1'b0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [W-1:0] q;
    bit z;
    bit n;
    bit e;
  } ent_t;
  ent_t mq[$];
  alu_result_mux_buf dut (
    .clk(clk), .rst(rst), .in_data(in_data), .alu_control(alu_control),
    .in_valid(in_valid), .in_ready(in_ready), .out_q(out_q), .out_zero(out_zero),
    .out_neg(out_neg), .out_sel_err(out_sel_err), .out_valid(out_valid), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic load_plan_inputs();
    logic [W-1:0] v[N];
    v = '{5'b10000, 5'b10001, 5'b00100, 5'b00010, 5'b00001, 5'b01010, 5'b01111, 5'b01010, 5'b00011, 5'b01000};
    for (int i = 0; i < N; i++) in_data[i*W +: W] = v[i];
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_q !== 5'b00000) begin errors++; $display("FAIL reset_q: got %b want 00000", out_q); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if ({out_zero, out_neg, out_sel_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {out_zero, out_neg, out_sel_err}); end
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask
  task automatic test_single();
    in_valid = 1'b1;
    alu_control = 4'b0000;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if ({out_valid, out_q, out_neg, out_zero} !== 8'b1_10000_1_0) begin errors++; $display("FAIL single_out: got v=%b q=%b n=%b z=%b want v=1 q=10000 n=1 z=0", out_valid, out_q, out_neg, out_zero); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pop: got %b want 0", out_valid); end
  endtask
  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1;
    alu_control = 4'b0001;
    tick();
    alu_control = 4'b0011;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
    alu_control = 4'b1001;
    tick();
    in_valid = 1'b0;
    checks++; if (out_q !== 5'b10001) begin errors++; $display("FAIL bp_hold: got %b want 10001", out_q); end
    out_ready = 1'b1;
    tick();
    checks++; if ({out_valid, out_q} !== 6'b1_00010) begin errors++; $display("FAIL bp_second: got v=%b q=%b want v=1 q=00010", out_valid, out_q); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", out_valid); end
  endtask
  task automatic test_out_of_range();
    out_ready = 1'b1;
    in_valid = 1'b1;
    alu_control = 4'b1100;
    tick();
    checks++; if ({out_valid, out_q, out_sel_err, out_zero} !== 8'b1_00000_1_0) begin errors++; $display("FAIL oor_entry: got v=%b q=%b e=%b z=%b want v=1 q=00000 e=1 z=0", out_valid, out_q, out_sel_err, out_zero); end
    alu_control = 4'b1001;
    tick();
    in_valid = 1'b0;
    checks++; if ({out_q, out_sel_err} !== 6'b01000_0) begin errors++; $display("FAIL oor_next: got q=%b e=%b want q=01000 e=0", out_q, out_sel_err); end
    tick();
  endtask
  task automatic test_streaming();
    logic [3:0] codes[3];
    logic [W-1:0] exp[3];
    codes = '{4'b0010, 4'b0100, 4'b0101};
    exp = '{5'b00100, 5'b00001, 5'b01010};
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_control = codes[i];
      tick();
      checks++; if ({out_valid, out_q, in_ready} !== {1'b1, exp[i], 1'b1}) begin errors++; $display("FAIL stream_%0d: got v=%b q=%b rdy=%b want v=1 q=%b rdy=1", i, out_valid, out_q, in_ready, exp[i]); end
    end
    in_valid = 1'b0;
    tick();
  endtask
  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1;
    alu_control = 4'b0000;
    tick();
    alu_control = 4'b0001;
    tick();
    in_valid = 1'b0;
    checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL mid_full: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({out_valid, out_q} !== 6'b0_00000) begin errors++; $display("FAIL mid_cleared: got v=%b q=%b want v=0 q=00000", out_valid, out_q); end
    tick();
    in_valid = 1'b1;
    alu_control = 4'b0110;
    tick();
    in_valid = 1'b0;
    checks++; if ({out_valid, out_q} !== 6'b1_01111) begin errors++; $display("FAIL mid_repush: got v=%b q=%b want v=1 q=01111", out_valid, out_q); end
    out_ready = 1'b1;
    tick();
  endtask
  task automatic test_random();
    logic [63:0] r;
    logic [NW-1:0] sh;
    bit mrst, mready, push, pop;
    int code;
    ent_t e;
    mrst = 1'b0;
    mq.delete();
    for (int c = 0; c < 500; c++) begin
      rst = $urandom_range(0, 59) == 0;
      in_valid = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      alu_control = 4'($urandom_range(0, 15));
      r = {$urandom(), $urandom()};
      in_data = r[NW-1:0];
      mready = !mrst && mq.size() < 2;
      checks++; if (in_ready !== mready) begin errors++; $display("FAIL rand_in_ready c=%0d: got %b want %b", c, in_ready, mready); end
      checks++; if (out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rand_valid c=%0d: got %b want %b", c, out_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        checks++; if ({out_q, out_zero, out_neg, out_sel_err} !== {mq[0].q, mq[0].z, mq[0].n, mq[0].e}) begin errors++; $display("FAIL rand_head c=%0d: got q=%b z=%b n=%b e=%b want q=%b z=%b n=%b e=%b", c, out_q, out_zero, out_neg, out_sel_err, mq[0].q, mq[0].z, mq[0].n, mq[0].e); end
      end
      push = in_valid && mready;
      pop = mq.size() != 0 && out_ready;
      code = int'(alu_control);
      sh = in_data >> (code * W);
      e.e = code >= N;
      e.q = e.e ? '0 : sh[W-1:0];
      e.z = !e.e && e.q == 0;
      e.n = e.q >= 16;
      tick();
      if (rst) begin
        mq.delete();
        mrst = 1'b1;
      end else begin
        mrst = 1'b0;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(e);
      end
    end
    rst = 1'b0;
    in_valid = 1'b0;
  endtask
  initial begin
    in_data = '0;
    load_plan_inputs();
    test_reset();
    test_single();
    test_backpressure();
    test_out_of_range();
    test_streaming();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
